// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction phase encoding and interrupt line limit.
package cpu_pkg;

    localparam int unsigned NUM_IRQ_MAX = 16;

    // One-hot so the phase outputs come straight off the state flops.
    typedef enum logic [3:0] {
        FETCH  = 4'b0001,
        DECODE = 4'b0010,
        EXEC   = 4'b0100,
        RDMEM  = 4'b1000
    } phase_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module irq_prio_enc
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 4,
    parameter int unsigned VW      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] i_req,
    output logic               o_any,
    output logic [VW-1:0]      o_idx
);

    always_comb begin
        o_any = |i_req;
        o_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = VW'(i);
            end
        end
    end

endmodule

// File: rtl/phase_irq_ctrl.sv
// Instruction phase sequencer with synchronised, prioritised interrupt entry
// injected at FETCH completion.
module phase_irq_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned          NUM_IRQ     = 4,
    parameter logic [NUM_IRQ-1:0]   IRQ_EDGE    = '1,
    parameter int unsigned          SYNC_STAGES = 2,
    localparam int unsigned         VW          = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               need_rdmem,
    input  logic               mem_ready,
    input  logic               set_ien,
    input  logic               clear_ien,
    input  logic [NUM_IRQ-1:0] clr_pend,
    output logic               phase_fetch,
    output logic               phase_decode,
    output logic               phase_exec,
    output logic               phase_rdmem,
    output logic               fetch_commit,
    output logic               irq_pend,
    output logic [VW-1:0]      irq_vec,
    output logic               ien,
    output logic [NUM_IRQ-1:0] pending
);

    if (NUM_IRQ < 1 || NUM_IRQ > NUM_IRQ_MAX) begin : g_bad_num_irq
        $error("phase_irq_ctrl: NUM_IRQ out of range");
    end
    if (SYNC_STAGES != 0 && SYNC_STAGES != 2) begin : g_bad_sync
        $error("phase_irq_ctrl: SYNC_STAGES must be 0 or 2");
    end

    phase_t             r_phase, w_phase_nxt;
    logic [NUM_IRQ-1:0] w_irq_s, r_irq_prev, w_rise, w_ack;
    logic [NUM_IRQ-1:0] r_pending, w_pending_nxt, w_eligible;
    logic               r_ien, r_irq_pend;
    logic [VW-1:0]      r_irq_vec, w_enc_idx;
    logic               w_enc_any, w_fetch_done, w_irq_take, w_exec;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign w_irq_s = irq;
    end else begin : g_sync
        logic [NUM_IRQ-1:0] r_sync1, r_sync2;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync1 <= '0;
                r_sync2 <= '0;
            end else begin
                r_sync1 <= irq;
                r_sync2 <= r_sync1;
            end
        end
        assign w_irq_s = r_sync2;
    end

    assign w_rise       = w_irq_s & ~r_irq_prev;
    assign w_eligible   = r_pending & irq_mask;
    assign w_fetch_done = (r_phase == FETCH) && mem_ready;
    assign w_irq_take   = w_fetch_done && r_ien && w_enc_any;
    assign w_exec       = (r_phase == EXEC);

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .VW      (VW)
    ) u_prio_enc (
        .i_req (w_eligible),
        .o_any (w_enc_any),
        .o_idx (w_enc_idx)
    );

    // Edge lines: a new edge beats any clear in the same cycle. Level lines track the input.
    always_comb begin
        w_ack         = '0;
        w_pending_nxt = r_pending;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_ack[i] = w_exec && r_irq_pend && (r_irq_vec == VW'(i));
            if (IRQ_EDGE[i]) begin
                if (w_rise[i]) begin
                    w_pending_nxt[i] = 1'b1;
                end else if (clr_pend[i] || w_ack[i]) begin
                    w_pending_nxt[i] = 1'b0;
                end
            end else begin
                w_pending_nxt[i] = w_irq_s[i];
            end
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        unique case (r_phase)
            FETCH:   if (mem_ready) w_phase_nxt = DECODE;
            DECODE:  w_phase_nxt = EXEC;
            EXEC:    w_phase_nxt = (need_rdmem && !r_irq_pend) ? RDMEM : FETCH;
            RDMEM:   if (mem_ready) w_phase_nxt = FETCH;
            default: w_phase_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= FETCH;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_prev <= '0;
            r_pending  <= '0;
            r_ien      <= 1'b0;
            r_irq_pend <= 1'b0;
            r_irq_vec  <= '0;
        end else begin
            r_irq_prev <= w_irq_s;
            r_pending  <= w_pending_nxt;
            if (w_fetch_done) begin
                r_irq_pend <= w_irq_take;
                r_irq_vec  <= w_irq_take ? w_enc_idx : '0;
            end
            if (w_exec) begin
                if (r_irq_pend) begin
                    r_ien <= 1'b0;
                end else if (clear_ien) begin
                    r_ien <= 1'b0;
                end else if (set_ien) begin
                    r_ien <= 1'b1;
                end
            end
        end
    end

    assign phase_fetch  = r_phase[0];
    assign phase_decode = r_phase[1];
    assign phase_exec   = r_phase[2];
    assign phase_rdmem  = r_phase[3];
    assign fetch_commit = w_fetch_done && !w_irq_take;
    assign irq_pend     = r_irq_pend;
    assign irq_vec      = r_irq_vec;
    assign ien          = r_ien;
    assign pending      = r_pending;

endmodule

// File: tb/tb_phase_irq_ctrl.sv
// Directed bench for phase_irq_ctrl: an all-edge instance and one with line 1 as level.
module tb_phase_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq, irq_l, irq_mask, clr_pend;
    logic       need_rdmem, mem_ready, set_ien, clear_ien;

    logic       ph_f_e, ph_d_e, ph_x_e, ph_r_e, fc_e, ipend_e, ien_e;
    logic [1:0] vec_e;
    logic [3:0] pend_e;
    logic       ph_f_l, ph_d_l, ph_x_l, ph_r_l, fc_l, ipend_l, ien_l;
    logic [1:0] vec_l;
    logic [3:0] pend_l;
    logic [3:0] ph_e;

    int checks   = 0;
    int failures = 0;

    assign ph_e = {ph_r_e, ph_x_e, ph_d_e, ph_f_e};

    always #5 clk = ~clk;

    phase_irq_ctrl #(
        .NUM_IRQ     (4),
        .IRQ_EDGE    (4'b1111),
        .SYNC_STAGES (2)
    ) dut_e (
        .clk          (clk),
        .rst          (rst),
        .irq          (irq),
        .irq_mask     (irq_mask),
        .need_rdmem   (need_rdmem),
        .mem_ready    (mem_ready),
        .set_ien      (set_ien),
        .clear_ien    (clear_ien),
        .clr_pend     (clr_pend),
        .phase_fetch  (ph_f_e),
        .phase_decode (ph_d_e),
        .phase_exec   (ph_x_e),
        .phase_rdmem  (ph_r_e),
        .fetch_commit (fc_e),
        .irq_pend     (ipend_e),
        .irq_vec      (vec_e),
        .ien          (ien_e),
        .pending      (pend_e)
    );

    phase_irq_ctrl #(
        .NUM_IRQ     (4),
        .IRQ_EDGE    (4'b1101),
        .SYNC_STAGES (2)
    ) dut_l (
        .clk          (clk),
        .rst          (rst),
        .irq          (irq_l),
        .irq_mask     (irq_mask),
        .need_rdmem   (need_rdmem),
        .mem_ready    (mem_ready),
        .set_ien      (set_ien),
        .clear_ien    (clear_ien),
        .clr_pend     (clr_pend),
        .phase_fetch  (ph_f_l),
        .phase_decode (ph_d_l),
        .phase_exec   (ph_x_l),
        .phase_rdmem  (ph_r_l),
        .fetch_commit (fc_l),
        .irq_pend     (ipend_l),
        .irq_vec      (vec_l),
        .ien          (ien_l),
        .pending      (pend_l)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        irq = '0; irq_l = '0; irq_mask = 4'b1111; clr_pend = '0;
        need_rdmem = 1'b0; mem_ready = 1'b1; set_ien = 1'b0; clear_ien = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_fetch();
        int n = 0;
        while (!ph_f_e && n < 20) begin
            tick(1);
            n++;
        end
        checks++;
        if (ph_f_e !== 1'b1) begin
            failures++;
            $display("FAIL wait_fetch timeout: phase=%b required FETCH", ph_e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        irq = '0; irq_l = '0; irq_mask = 4'b1111; clr_pend = '0;
        need_rdmem = 1'b0; mem_ready = 1'b1; set_ien = 1'b0; clear_ien = 1'b0;
        #1;
        checks++;
        if ({ph_e, ipend_e, vec_e, ien_e, pend_e} !== {4'b0001, 1'b0, 2'b00, 1'b0, 4'b0000}) begin
            failures++;
            $display("FAIL reset_state: ph=%b ipend=%b vec=%0d ien=%b pend=%b required 0001/0/0/0/0000",
                     ph_e, ipend_e, vec_e, ien_e, pend_e);
        end
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_phase();
        logic [3:0] seq3 [3] = '{4'b0010, 4'b0100, 4'b0001};
        logic [3:0] seq4 [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checks++;
            if (ph_e !== seq3[i]) begin
                failures++;
                $display("FAIL phase_no_rdmem step %0d: got %b required %b", i, ph_e, seq3[i]);
            end
        end
        need_rdmem = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checks++;
            if (ph_e !== seq4[i]) begin
                failures++;
                $display("FAIL phase_rdmem step %0d: got %b required %b", i, ph_e, seq4[i]);
            end
        end
        need_rdmem = 1'b0;
        mem_ready  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            checks++;
            if (ph_e !== 4'b0001 || fc_e !== 1'b0) begin
                failures++;
                $display("FAIL fetch_stall %0d: phase=%b fc=%b required 0001/0", i, ph_e, fc_e);
            end
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (fc_e !== 1'b1) begin
            failures++;
            $display("FAIL fetch_commit_ready: got %b required 1", fc_e);
        end
        tick(1);
        checks++;
        if (ph_e !== 4'b0010) begin
            failures++;
            $display("FAIL fetch_stall_exit: got %b required 0010", ph_e);
        end
        wait_fetch();
    endtask

    task automatic test_irq_prio();
        do_reset();
        set_ien = 1'b1;
        tick(3);
        set_ien = 1'b0;
        checks++;
        if (ien_e !== 1'b1) begin
            failures++;
            $display("FAIL prio_ien_set: got %b required 1", ien_e);
        end
        irq = 4'b0110;
        tick(3);
        #1;
        checks++;
        if (pend_e !== 4'b0110 || fc_e !== 1'b0) begin
            failures++;
            $display("FAIL prio_take: pend=%b fc=%b required 0110/0", pend_e, fc_e);
        end
        tick(1);
        checks++;
        if (ipend_e !== 1'b1 || vec_e !== 2'd1) begin
            failures++;
            $display("FAIL prio_vec: ipend=%b vec=%0d required 1/1", ipend_e, vec_e);
        end
        tick(2);
        checks++;
        if (ien_e !== 1'b0 || pend_e !== 4'b0100 || ph_e !== 4'b0001) begin
            failures++;
            $display("FAIL prio_after_exec: ien=%b pend=%b ph=%b required 0/0100/0001",
                     ien_e, pend_e, ph_e);
        end
        irq = '0;
        clr_pend = 4'b1111;
        tick(1);
        clr_pend = '0;
        checks++;
        if (pend_e !== 4'b0000) begin
            failures++;
            $display("FAIL prio_clr_pend: got %b required 0000", pend_e);
        end
        wait_fetch();
    endtask

    task automatic test_ien_gate();
        irq = 4'b1000;
        tick(3);
        checks++;
        if (pend_e[3] !== 1'b1 || fc_e !== 1'b1) begin
            failures++;
            $display("FAIL gate_pending: pend=%b fc=%b required 1xxx/1", pend_e, fc_e);
        end
        set_ien = 1'b1;
        tick(1);
        checks++;
        if (ipend_e !== 1'b0) begin
            failures++;
            $display("FAIL gate_no_take: ipend=%b required 0", ipend_e);
        end
        tick(2);
        set_ien = 1'b0;
        checks++;
        if (ien_e !== 1'b1 || fc_e !== 1'b0) begin
            failures++;
            $display("FAIL gate_ien_on: ien=%b fc=%b required 1/0", ien_e, fc_e);
        end
        tick(1);
        checks++;
        if (ipend_e !== 1'b1 || vec_e !== 2'd3) begin
            failures++;
            $display("FAIL gate_vec: ipend=%b vec=%0d required 1/3", ipend_e, vec_e);
        end
        tick(2);
        irq = '0;
        checks++;
        if (ien_e !== 1'b0 || pend_e !== 4'b0000) begin
            failures++;
            $display("FAIL gate_ack: ien=%b pend=%b required 0/0000", ien_e, pend_e);
        end
    endtask

    task automatic test_set_wins();
        irq = 4'b0001;
        tick(2);
        clr_pend = 4'b0001;
        tick(1);
        clr_pend = '0;
        checks++;
        if (pend_e[0] !== 1'b1) begin
            failures++;
            $display("FAIL set_beats_clr: pend=%b required xxx1", pend_e);
        end
        clr_pend = 4'b0001;
        tick(1);
        clr_pend = '0;
        irq = '0;
        checks++;
        if (pend_e[0] !== 1'b0) begin
            failures++;
            $display("FAIL clr_alone: pend=%b required xxx0", pend_e);
        end
        wait_fetch();
    endtask

    task automatic test_level();
        logic exp_take [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        set_ien = 1'b1;
        irq_l   = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checks++;
            if (ipend_l !== exp_take[i] || (exp_take[i] && vec_l !== 2'd1)) begin
                failures++;
                $display("FAIL level_retake insn %0d: ipend=%b vec=%0d required %b/1",
                         i, ipend_l, vec_l, exp_take[i]);
            end
            tick(2);
        end
        checks++;
        if (ien_l !== 1'b0 || pend_l !== 4'b0010) begin
            failures++;
            $display("FAIL level_hold: ien=%b pend=%b required 0/0010", ien_l, pend_l);
        end
        irq_l = '0;
        tick(1);
        checks++;
        if (ipend_l !== 1'b0) begin
            failures++;
            $display("FAIL level_idle_insn: ipend=%b required 0", ipend_l);
        end
        tick(2);
        checks++;
        if (ien_l !== 1'b1 || pend_l !== 4'b0000) begin
            failures++;
            $display("FAIL level_dropped: ien=%b pend=%b required 1/0000", ien_l, pend_l);
        end
        tick(1);
        checks++;
        if (ipend_l !== 1'b0) begin
            failures++;
            $display("FAIL level_no_take: ipend=%b required 0", ipend_l);
        end
        set_ien = 1'b0;
        wait_fetch();
    endtask

    task automatic test_reset_rdmem();
        do_reset();
        set_ien  = 1'b1;
        irq_mask = 4'b0000;
        irq      = 4'b0001;
        tick(3);
        set_ien    = 1'b0;
        need_rdmem = 1'b1;
        tick(2);
        mem_ready = 1'b0;
        tick(1);
        checks++;
        if (ph_e !== 4'b1000 || ien_e !== 1'b1 || pend_e !== 4'b0001) begin
            failures++;
            $display("FAIL rdmem_pre_reset: ph=%b ien=%b pend=%b required 1000/1/0001",
                     ph_e, ien_e, pend_e);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ph_e, ipend_e, vec_e, ien_e, pend_e} !== {4'b0001, 1'b0, 2'b00, 1'b0, 4'b0000}) begin
            failures++;
            $display("FAIL async_reset: ph=%b ipend=%b vec=%0d ien=%b pend=%b required 0001/0/0/0/0000",
                     ph_e, ipend_e, vec_e, ien_e, pend_e);
        end
        tick(1);
        rst        = 1'b0;
        need_rdmem = 1'b0;
        mem_ready  = 1'b1;
        tick(1);
        checks++;
        if (ph_e !== 4'b0010) begin
            failures++;
            $display("FAIL restart_phase: got %b required 0010", ph_e);
        end
        tick(1);
        checks++;
        if (pend_e !== 4'b0000) begin
            failures++;
            $display("FAIL post_reset_sync_latency: pend=%b required 0000", pend_e);
        end
        tick(1);
        checks++;
        if (pend_e !== 4'b0001 || ph_e !== 4'b0001) begin
            failures++;
            $display("FAIL post_reset_edge: pend=%b ph=%b required 0001/0001", pend_e, ph_e);
        end
        irq      = '0;
        irq_mask = 4'b1111;
    endtask

    initial begin
        test_reset();
        test_phase();
        test_irq_prio();
        test_ien_gate();
        test_set_wins();
        test_level();
        test_reset_rdmem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
